registrador_universal_param: RTL and testbench
==============================================

Name: registrador_universal_param

Overview:
Parametrised universal register with a multi-cycle shift sequencer. It replaces the fixed 7-bit hand-wired per-bit register cells. It adds:
- configurable width;
- rotate, arithmetic-shift and clear modes;
- N-position shift commands executed one position per cycle, under a valid/ready command handshake, with a pause input and a done pulse.

It sits between the control FSM and datapath registers wherever a loadable, shiftable register is needed.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CW, $clog2(WIDTH+1), width of the shift-count field (derived; do not override)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command (high only in IDLE)
modo  in  3  command mode, sampled on acceptance
qtd  in  CW  number of positions for shift/rotate modes, sampled on acceptance
d_paralelo  in  WIDTH  parallel load value, sampled on acceptance
sinal  in  1  run enable; 0 freezes an in-progress shift
sin_lsb  in  1  serial bit entering bit 0 on a left shift
sin_msb  in  1  serial bit entering bit WIDTH-1 on a logical right shift
q  out  WIDTH  register contents (registered)
sout_msb  out  1  q[WIDTH-1], combinational
sout_lsb  out  1  q[0], combinational
busy  out  1  high in SHIFT state
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, any state):
  - q=0, state=IDLE, counter=0, done=0, busy=0, latched mode=NOP.
  - Reset mid-shift aborts the command; no done pulse.
- Modes:
  - 000 NOP
  - 001 LOAD
  - 010 SHL, logical left: q <= {q[W-2:0], sin_lsb}
  - 011 SHR, logical right: q <= {sin_msb, q[W-1:1]}
  - 100 ROL: q <= {q[W-2:0], q[W-1]}
  - 101 ROR: q <= {q[0], q[W-1:1]}
  - 110 CLR
  - 111 ASR: q <= {q[W-1], q[W-1:1]}
- Acceptance occurs when cmd_valid & cmd_ready at a rising edge.
- States: IDLE, SHIFT. cmd_ready = (state==IDLE); busy = (state==SHIFT).
- IDLE, on accept:
  - NOP: q unchanged; done=1 next cycle.
  - LOAD: q <= d_paralelo at the accept edge; done=1 in the following cycle.
  - CLR: q <= 0; done=1.
  - Shift/rotate mode with qtd=0: q unchanged; done=1; stay IDLE.
  - Shift/rotate mode with qtd>0:
    - latch mode; counter <= min(qtd, WIDTH); go to SHIFT.
    - No shift happens on the accept edge.
- SHIFT, each edge:
  - sinal=1: perform one shift of the latched mode; counter-1.
    - If counter was 1: go to IDLE and set done=1, so done coincides with q holding the final value.
  - sinal=0: hold q, counter and state.
  - cmd_valid is ignored (cmd_ready=0).
- sinal is ignored in IDLE. Single-cycle commands complete regardless of sinal.
- qtd > WIDTH is clamped to WIDTH.
  - ROL/ROR by WIDTH therefore restores the original q.
  - SHL/SHR by WIDTH fills q entirely with serial inputs.
- Serial inputs are sampled on every shift edge, not latched at acceptance.
- done is registered and high for exactly one cycle per completed command.
- A new command may be accepted in the same cycle done is high, since that cycle is IDLE.
- Latency:
  - NOP/LOAD/CLR, and shifts with qtd=0: 1 cycle from acceptance to done.
  - qtd>0 shifts: counter cycles with sinal=1 plus any pause cycles, after acceptance.

Decomposition:
- Shared package registrador_pkg holds:
  - mode localparams MODO_NOP..MODO_ASR (3 bits);
  - state encoding ST_IDLE/ST_SHIFT.
- One natural sub-module: registrador_universal_prox, a combinational next-value function (q, mode, sin_lsb, sin_msb -> next q for one position), parametrised by WIDTH.
- The sequencer FSM, counter and storage stay in the top module.

Test Plan:
1. WIDTH=8. Reset asserted mid-SHIFT, between edges. Required: q=0x00, busy=0, cmd_ready=1 immediately; no done pulse.
2. LOAD d_paralelo=0xA5. Required: q=0xA5 after the accept edge; done=1 for one cycle; cmd_ready stays 1.
3. LOAD 0x81, then ROL qtd=3 with sinal=1. Required: busy for 3 cycles; q steps 0x03, 0x06, 0x0C; done coincides with q=0x0C.
4. LOAD 0x90, then ASR qtd=2, with sinal=0 for 2 cycles after the first shift. Required: q=0xC8 held through the pause, then 0xE4 with done; total 4 cycles from acceptance.
5. SHR qtd=15 (clamped to 8) with q=0xFF, sin_msb=0. Required: 8 shift cycles, q=0x00; SHL qtd=0 gives done next cycle with q unchanged.
6. cmd_valid held high during SHIFT with LOAD 0x11 presented. Required: ignored until IDLE; accepted on the done cycle; q=0x11 one cycle later.

Source files
------------

// File: rtl/registrador_pkg.sv
// ============================================================================
// Module      : registrador_pkg
// Description : Shared mode codes, FSM state encoding and helpers for the
//               universal register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package registrador_pkg;

    localparam logic [2:0] MODO_NOP = 3'b000;
    localparam logic [2:0] MODO_LOAD = 3'b001;
    localparam logic [2:0] MODO_SHL = 3'b010;
    localparam logic [2:0] MODO_SHR = 3'b011;
    localparam logic [2:0] MODO_ROL = 3'b100;
    localparam logic [2:0] MODO_ROR = 3'b101;
    localparam logic [2:0] MODO_CLR = 3'b110;
    localparam logic [2:0] MODO_ASR = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } estado_t;

    // True for modes that step one position per cycle under the sequencer.
    function automatic logic modo_desloca(input logic [2:0] m);
        return (m == MODO_SHL) || (m == MODO_SHR) || (m == MODO_ROL) ||
               (m == MODO_ROR) || (m == MODO_ASR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/registrador_universal_prox.sv
// ============================================================================
// Module      : registrador_universal_prox
// Description : Combinational one-position next value for the shift/rotate
//               modes; non-shift modes pass q through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registrador_universal_prox
    import registrador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       modo_i,
    input  logic             sin_lsb_i,
    input  logic             sin_msb_i,
    output logic [WIDTH-1:0] q_prox_o
);

    always_comb begin
        q_prox_o = q_i;
        case (modo_i)
            MODO_SHL: q_prox_o = {q_i[WIDTH-2:0], sin_lsb_i};
            MODO_SHR: q_prox_o = {sin_msb_i, q_i[WIDTH-1:1]};
            MODO_ROL: q_prox_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODO_ROR: q_prox_o = {q_i[0], q_i[WIDTH-1:1]};
            MODO_ASR: q_prox_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default:  q_prox_o = q_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/registrador_universal_param.sv
// ============================================================================
// Module      : registrador_universal_param
// Description : Parametrised universal register with a valid/ready command
//               interface and a pausable multi-cycle shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registrador_universal_param
    import registrador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       modo,
    input  logic [CW-1:0]    qtd,
    input  logic [WIDTH-1:0] d_paralelo,
    input  logic             sinal,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    estado_t          state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       modo_q, modo_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_prox;

    registrador_universal_prox #(
        .WIDTH (WIDTH)
    ) u_prox (
        .q_i       (q_q),
        .modo_i    (modo_q),
        .sin_lsb_i (sin_lsb),
        .sin_msb_i (sin_msb),
        .q_prox_o  (q_prox)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            modo_q  <= MODO_NOP;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            modo_q  <= modo_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        modo_d  = modo_q;
        q_d     = q_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (modo == MODO_LOAD) begin
                        q_d    = d_paralelo;
                        done_d = 1'b1;
                    end else if (modo == MODO_CLR) begin
                        q_d    = '0;
                        done_d = 1'b1;
                    end else if (modo_desloca(modo) && (qtd != '0)) begin
                        // Nothing moves on the accept edge; the first shift
                        // happens on the next run-enabled edge.
                        modo_d  = modo;
                        cnt_d   = (qtd > CNT_MAX) ? CNT_MAX : qtd;
                        state_d = ST_SHIFT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (sinal) begin
                    q_d   = q_prox;
                    cnt_d = cnt_q - CNT_UM;
                    if (cnt_q == CNT_UM) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign q         = q_q;
    assign sout_msb  = q_q[WIDTH-1];
    assign sout_lsb  = q_q[0];
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_registrador_universal_param.sv
// ============================================================================
// Module      : tb_registrador_universal_param
// Description : Self-checking bench for the universal register (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_registrador_universal_param;

    localparam int W = 8;
    localparam int CWT = $clog2(W + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     modo = 3'd0;
    logic [CWT-1:0] qtd = '0;
    logic [W-1:0]   d_paralelo = '0;
    logic           sinal = 1'b0;
    logic           sin_lsb = 1'b0;
    logic           sin_msb = 1'b0;
    logic [W-1:0]   q;
    logic           sout_msb, sout_lsb, busy, done;

    int errors = 0;
    int checks = 0;
    int mq = 0;

    registrador_universal_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .modo       (modo),
        .qtd        (qtd),
        .d_paralelo (d_paralelo),
        .sinal      (sinal),
        .sin_lsb    (sin_lsb),
        .sin_msb    (sin_msb),
        .q          (q),
        .sout_msb   (sout_msb),
        .sout_lsb   (sout_lsb),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: one position of each mode as plain integer arithmetic.
    function automatic int model_shift(input int m, input int v, input int sl, input int sm);
        int full = 1 << W;
        int half = 1 << (W - 1);
        case (m)
            2: return (v * 2 + sl) % full;
            3: return v / 2 + sm * half;
            4: return (v * 2) % full + v / half;
            5: return v / 2 + (v % 2) * half;
            7: return v / 2 + ((v >= half) ? half : 0);
            default: return v;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input int n, input int d);
        cmd_valid  = 1'b1;
        modo       = 3'(m);
        qtd        = CWT'(n);
        d_paralelo = W'(d);
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b ready=%b done=%b want 0 1 0", busy, cmd_ready, done); end
        rst = 1'b0;
        issue(1, 0, 8'h5A);
        tick();
        sinal = 1'b1;
        issue(3, 6, 0);
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got q=%h busy=%b ready=%b want 00 0 1", q, busy, cmd_ready); end
        tick();
        rst = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_no_done got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b0 || q !== 8'h00) begin
            errors++; $display("FAIL reset_after got done=%b q=%h want 0 00", done, q); end
        sinal = 1'b0;
        mq = 0;
    endtask

    task automatic test_load;
        issue(1, 0, 8'hA5);
        checks++; if (q !== 8'hA5 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL load got q=%h done=%b ready=%b want a5 1 1", q, done, cmd_ready); end
        tick();
        checks++; if (done !== 1'b0 || q !== 8'hA5) begin
            errors++; $display("FAIL load_pulse got done=%b q=%h want 0 a5", done, q); end
        mq = 'hA5;
    endtask

    task automatic test_rol;
        logic [7:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
        issue(1, 0, 8'h81);
        tick();
        sinal = 1'b1;
        issue(4, 3, 0);
        checks++; if (busy !== 1'b1 || q !== 8'h81 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rol_accept got busy=%b q=%h ready=%b want 1 81 0", busy, q, cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== exp_q[i] || done !== (i == 2) || busy !== (i != 2)) begin
                errors++; $display("FAIL rol_step%0d got q=%h done=%b busy=%b want %h %b %b",
                                   i, q, done, busy, exp_q[i], i == 2, i != 2); end
        end
        mq = 'h0C;
    endtask

    task automatic test_asr_pause;
        issue(1, 0, 8'h90);
        tick();
        sinal = 1'b1;
        issue(7, 2, 0);
        tick();
        checks++; if (q !== 8'hC8 || done !== 1'b0) begin
            errors++; $display("FAIL asr_first got q=%h done=%b want c8 0", q, done); end
        sinal = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (q !== 8'hC8 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL asr_pause%0d got q=%h busy=%b done=%b want c8 1 0", i, q, busy, done); end
        end
        sinal = 1'b1;
        tick();
        checks++; if (q !== 8'hE4 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL asr_done got q=%h done=%b busy=%b want e4 1 0", q, done, busy); end
        mq = 'hE4;
    endtask

    task automatic test_clamp;
        int cyc = 0;
        issue(1, 0, 8'hFF);
        tick();
        sin_msb = 1'b0;
        sinal = 1'b1;
        issue(3, 15, 0);
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (cyc !== 8 || q !== 8'h00) begin
            errors++; $display("FAIL shr_clamp got cycles=%0d q=%h want 8 00", cyc, q); end
        issue(1, 0, 8'h3C);
        sin_lsb = 1'b1;
        issue(2, 0, 0);
        checks++; if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL shl_zero got q=%h done=%b busy=%b want 3c 1 0", q, done, busy); end
        sin_lsb = 1'b0;
        mq = 'h3C;
    endtask

    task automatic test_back_to_back;
        issue(1, 0, 8'h60);
        tick();
        sinal = 1'b1;
        cmd_valid = 1'b1; modo = 3'd4; qtd = CWT'(2);
        tick();
        modo = 3'd1; d_paralelo = 8'h11;
        tick();
        checks++; if (q !== 8'hC0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_ignored got q=%h busy=%b want c0 1", q, busy); end
        tick();
        checks++; if (q !== 8'h81 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_done got q=%h done=%b ready=%b want 81 1 1", q, done, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (q !== 8'h11 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_load got q=%h done=%b want 11 1", q, done); end
        mq = 'h11;
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            int m = int'($urandom_range(0, 7));
            int n = int'($urandom_range(0, 15));
            int d = int'($urandom_range(0, 255));
            int cnt = 0;
            int budget = 0;
            sinal = 1'($urandom);
            issue(m, n, d);
            if (m == 1) mq = d;
            else if (m == 6) mq = 0;
            if (m inside {2, 3, 4, 5, 7} && n > 0) cnt = (n > W) ? W : n;
            checks++; if (q !== W'(mq) || busy !== (cnt != 0) || done !== (cnt == 0)) begin
                errors++; $display("FAIL rnd_accept%0d m=%0d n=%0d got q=%h busy=%b done=%b want %h %b %b",
                                   k, m, n, q, busy, done, mq, cnt != 0, cnt == 0); end
            while (cnt > 0 && budget < 100) begin
                int sl = int'($urandom_range(0, 1));
                int sm = int'($urandom_range(0, 1));
                sinal   = ($urandom_range(0, 3) != 0);
                sin_lsb = 1'(sl);
                sin_msb = 1'(sm);
                tick();
                budget++;
                if (sinal) begin
                    mq = model_shift(m, mq, sl, sm);
                    cnt--;
                end
                checks++; if (q !== W'(mq) || done !== (cnt == 0) || busy !== (cnt != 0) ||
                              sout_msb !== q[W-1] || sout_lsb !== q[0]) begin
                    errors++; $display("FAIL rnd_step%0d m=%0d got q=%h done=%b busy=%b want %h %b %b",
                                       k, m, q, done, busy, mq, cnt == 0, cnt != 0); end
            end
            tick();
            checks++; if (done !== 1'b0 || q !== W'(mq)) begin
                errors++; $display("FAIL rnd_idle%0d got done=%b q=%h want 0 %h", k, done, q, mq); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rol();
        test_asr_pause();
        test_clamp();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
